// File: rtl/fp32_pkg.sv
// Shared fp32 types, constants and helpers for the pipelined multiplier.
// Flag bits are ordered {invalid, overflow, underflow, inexact}, bit 3 down to 0.
package fp32_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  // Subnormals have exp=0 and therefore classify as ZERO (flush-to-zero).
  function automatic fp_class_e fp_classify(input fp32_t v);
    fp_class_e c;
    if (v.exp == 8'd0) begin
      c = ZERO;
    end else if (v.exp == 8'(EXP_MAX)) begin
      c = (v.frac == '0) ? INF : NAN;
    end else begin
      c = NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp32_round_norm.sv
// Combinational normalize / round-to-nearest-even / range check for a
// normal x normal significand product, feeding the output register stage.
module fp32_round_norm
  import fp32_pkg::*;
(
  input  logic               sign_i,
  input  logic [47:0]        prod_i,
  input  logic signed [9:0]  exp_i,
  output logic [31:0]        p_o,
  output logic [3:0]         flags_o
);

  localparam logic signed [9:0] EXP_OVF = 10'(EXP_MAX);

  logic [22:0]       frac_trunc;
  logic [22:0]       frac_fin;
  logic              carry;
  logic              g;
  logic              r;
  logic              s;
  logic              inc;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_fin;

  always_comb begin
    frac_trunc = '0;
    g          = 1'b0;
    r          = 1'b0;
    s          = 1'b0;
    exp_norm   = exp_i;
    p_o        = '0;
    flags_o    = '0;

    if (prod_i[47]) begin
      frac_trunc = prod_i[46:24];
      g          = prod_i[23];
      r          = prod_i[22];
      s          = |prod_i[21:0];
      exp_norm   = exp_i + 10'sd1;
    end else begin
      frac_trunc = prod_i[45:23];
      g          = prod_i[22];
      r          = prod_i[21];
      s          = |prod_i[20:0];
    end

    inc               = g & (r | s | frac_trunc[0]);
    {carry, frac_fin} = {1'b0, frac_trunc} + {23'd0, inc};
    // A carry out of the fraction leaves frac_fin at zero, i.e. mantissa 1.0.
    exp_fin = carry ? (exp_norm + 10'sd1) : exp_norm;

    if (exp_fin <= 10'sd0) begin
      p_o              = {sign_i, 31'd0};
      flags_o[FLG_UNF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end else if (exp_fin >= EXP_OVF) begin
      p_o              = PINF | {sign_i, 31'd0};
      flags_o[FLG_OVF] = 1'b1;
      flags_o[FLG_INX] = 1'b1;
    end else begin
      p_o              = {sign_i, exp_fin[7:0], frac_fin};
      flags_o[FLG_INX] = g | r | s;
    end
  end

endmodule

// File: rtl/fp32_mul_pipe.sv
// Three-stage fp32 multiplier (unpack, multiply, normalize/round) with a
// valid/ready handshake; a stall freezes all stages together.
module fp32_mul_pipe
  import fp32_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N_BITS-1:0] p_o,
  output logic [3:0]        flags_o
);

  if (N_BITS != 32) begin : g_width_check
    $error("fp32_mul_pipe supports only N_BITS = 32");
  end

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  fp32_t a_f;
  fp32_t b_f;
  assign a_f = a_i;
  assign b_f = b_i;

  logic stall;
  logic advance;

  logic             valid1_q, valid1_d;
  logic             sign1_q, sign1_d;
  fp_class_e        cls_a1_q, cls_a1_d;
  fp_class_e        cls_b1_q, cls_b1_d;
  logic [EXP_W-1:0] exp_a1_q, exp_a1_d;
  logic [EXP_W-1:0] exp_b1_q, exp_b1_d;
  logic [MAN_W:0]   man_a1_q, man_a1_d;
  logic [MAN_W:0]   man_b1_q, man_b1_d;

  logic                   valid2_q, valid2_d;
  logic                   sign2_q, sign2_d;
  logic [2*MAN_W+1:0]     prod2_q, prod2_d;
  logic signed [9:0]      exp2_q, exp2_d;
  logic                   spec2_q, spec2_d;
  logic [N_BITS-1:0]      spec_p2_q, spec_p2_d;
  logic [3:0]             spec_f2_q, spec_f2_d;

  logic              valid_q, valid_d;
  logic [N_BITS-1:0] p_q, p_d;
  logic [3:0]        flags_q, flags_d;

  logic [31:0] rn_p;
  logic [3:0]  rn_flags;

  fp32_round_norm u_round_norm (
    .sign_i  (sign2_q),
    .prod_i  (prod2_q),
    .exp_i   (exp2_q),
    .p_o     (rn_p),
    .flags_o (rn_flags)
  );

  assign stall   = valid_q & ~ready_i;
  assign advance = ~stall;
  assign ready_o = advance;
  assign valid_o = valid_q;
  assign p_o     = p_q;
  assign flags_o = flags_q;

  always_comb begin
    valid1_d  = valid1_q;
    sign1_d   = sign1_q;
    cls_a1_d  = cls_a1_q;
    cls_b1_d  = cls_b1_q;
    exp_a1_d  = exp_a1_q;
    exp_b1_d  = exp_b1_q;
    man_a1_d  = man_a1_q;
    man_b1_d  = man_b1_q;
    valid2_d  = valid2_q;
    sign2_d   = sign2_q;
    prod2_d   = prod2_q;
    exp2_d    = exp2_q;
    spec2_d   = spec2_q;
    spec_p2_d = spec_p2_q;
    spec_f2_d = spec_f2_q;
    valid_d   = valid_q;
    p_d       = p_q;
    flags_d   = flags_q;

    if (advance) begin
      valid1_d = valid_i;
      if (valid_i) begin
        sign1_d  = a_f.sign ^ b_f.sign;
        cls_a1_d = fp_classify(a_f);
        cls_b1_d = fp_classify(b_f);
        exp_a1_d = a_f.exp;
        exp_b1_d = b_f.exp;
        man_a1_d = {1'b1, a_f.frac};
        man_b1_d = {1'b1, b_f.frac};
      end

      valid2_d = valid1_q;
      if (valid1_q) begin
        sign2_d   = sign1_q;
        prod2_d   = {{(MAN_W+1){1'b0}}, man_a1_q} * {{(MAN_W+1){1'b0}}, man_b1_q};
        exp2_d    = $signed({2'b00, exp_a1_q}) + $signed({2'b00, exp_b1_q}) - BIAS_S;
        spec2_d   = 1'b1;
        spec_f2_d = '0;
        // Special operands bypass the arithmetic path entirely.
        if (cls_a1_q == NAN || cls_b1_q == NAN) begin
          spec_p2_d = QNAN;
        end else if ((cls_a1_q == INF && cls_b1_q == ZERO) ||
                     (cls_a1_q == ZERO && cls_b1_q == INF)) begin
          spec_p2_d          = QNAN;
          spec_f2_d[FLG_INV] = 1'b1;
        end else if (cls_a1_q == INF || cls_b1_q == INF) begin
          spec_p2_d = PINF | {sign1_q, {(N_BITS-1){1'b0}}};
        end else if (cls_a1_q == ZERO || cls_b1_q == ZERO) begin
          spec_p2_d = {sign1_q, {(N_BITS-1){1'b0}}};
        end else begin
          spec2_d   = 1'b0;
          spec_p2_d = '0;
        end
      end

      valid_d = valid2_q;
      if (valid2_q) begin
        p_d     = spec2_q ? spec_p2_q : rn_p;
        flags_d = spec2_q ? spec_f2_q : rn_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q  <= 1'b0;
      sign1_q   <= 1'b0;
      cls_a1_q  <= ZERO;
      cls_b1_q  <= ZERO;
      exp_a1_q  <= '0;
      exp_b1_q  <= '0;
      man_a1_q  <= '0;
      man_b1_q  <= '0;
      valid2_q  <= 1'b0;
      sign2_q   <= 1'b0;
      prod2_q   <= '0;
      exp2_q    <= '0;
      spec2_q   <= 1'b0;
      spec_p2_q <= '0;
      spec_f2_q <= '0;
      valid_q   <= 1'b0;
      p_q       <= '0;
      flags_q   <= '0;
    end else begin
      valid1_q  <= valid1_d;
      sign1_q   <= sign1_d;
      cls_a1_q  <= cls_a1_d;
      cls_b1_q  <= cls_b1_d;
      exp_a1_q  <= exp_a1_d;
      exp_b1_q  <= exp_b1_d;
      man_a1_q  <= man_a1_d;
      man_b1_q  <= man_b1_d;
      valid2_q  <= valid2_d;
      sign2_q   <= sign2_d;
      prod2_q   <= prod2_d;
      exp2_q    <= exp2_d;
      spec2_q   <= spec2_d;
      spec_p2_q <= spec_p2_d;
      spec_f2_q <= spec_f2_d;
      valid_q   <= valid_d;
      p_q       <= p_d;
      flags_q   <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Scoreboard bench for fp32_mul_pipe: a driver pushes hand-computed results
// at accept time, a negedge monitor pops and compares on every transfer.
module tb_fp32_mul_pipe;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [31:0] a_i     = '0;
  logic [31:0] b_i     = '0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] p_o;
  logic [3:0]  flags_o;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  f;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [31:0] s_b [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] s_p [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                           32'h41000000, 32'h41200000, 32'h41400000};

  fp32_mul_pipe dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .p_o     (p_o),
    .flags_o (flags_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Holds the operands until the edge that accepts them; push=0 issues an
  // operation whose result must never appear (discarded by reset).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] p, input logic [3:0] f,
                               input bit push, input bit chk_lat);
    int n = 0;
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    while (!ready_o && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: ready_o stuck at %b, expected 1", ready_o);
      valid_i = 1'b0;
      return;
    end
    if (push) sb_q.push_back('{p: p, f: f, acc: cyc + 1, chk_lat: chk_lat});
    @(posedge clk);
    #2;
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got p_o=%h flags_o=%b, expected no result", p_o, flags_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("p_o", p_o, e.p);
        checkOutput("flags_o", 32'(flags_o), 32'(e.f));
        if (e.chk_lat) checkOutput("latency_edges", 32'(cyc - e.acc + 1), 32'd3);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] fp32_mul_pipe bench starting");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset_p_o", p_o, 32'd0);
    checkOutput("reset_flags_o", 32'(flags_o), 32'd0);
    checkOutput("reset_ready_o", 32'(ready_o), 32'd1);

    // Arithmetic, rounding and range boundaries.
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1, 1);
    applyStimulus(32'hC0400000, 32'h3F000000, 32'hBFC00000, 4'b0000, 1, 1);
    applyStimulus(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 1, 1);
    applyStimulus(32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001, 1, 1);
    applyStimulus(32'h3FC00000, 32'h3F800003, 32'h3FC00004, 4'b0001, 1, 1);
    applyStimulus(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001, 1, 1);
    applyStimulus(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 1, 1);
    applyStimulus(32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 1, 1);
    applyStimulus(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 1, 1);
    applyStimulus(32'hFF000000, 32'h7F000000, 32'hFF800000, 4'b0101, 1, 1);
    applyStimulus(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 1, 1);
    applyStimulus(32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 1, 1);
    applyStimulus(32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 1, 1);
    // Special operands.
    applyStimulus(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, 1);
    applyStimulus(32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1, 1);
    applyStimulus(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 1, 1);
    applyStimulus(32'hFFC00000, 32'h00000000, 32'h7FC00000, 4'b0000, 1, 1);
    applyStimulus(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1, 1);
    applyStimulus(32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000, 1, 1);
    applyStimulus(32'hBF800000, 32'h00000000, 32'h80000000, 4'b0000, 1, 1);
    applyStimulus(32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, 1, 1);
    wait_drain();

    // Six-deep stream with a four-cycle downstream stall after the first result.
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(32'h40000000, s_b[i], s_p[i], 4'b0000, 1, 0);
      end
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!valid_o && n < 40);
        checkOutput("stall_first_valid", 32'(valid_o), 32'd1);
        @(posedge clk);
        #1 ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checkOutput("stall_ready_o", 32'(ready_o), 32'd0);
          checkOutput("stall_valid_o", 32'(valid_o), 32'd1);
          checkOutput("stall_hold_p_o", p_o, 32'h40800000);
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    wait_drain();

    // Reset with three operations in flight.
    @(posedge clk);
    #1 ready_i = 1'b0;
    applyStimulus(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 0, 0);
    applyStimulus(32'h40800000, 32'h40400000, 32'h41400000, 4'b0000, 0, 0);
    applyStimulus(32'h40A00000, 32'h40400000, 32'h41700000, 4'b0000, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_valid_o", 32'(valid_o), 32'd0);
    checkOutput("midreset_p_o", p_o, 32'd0);
    checkOutput("midreset_flags_o", 32'(flags_o), 32'd0);
    checkOutput("midreset_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1 ready_i = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1, 1);
    wait_drain();

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
